fp_align_ctrl: RTL and testbench

- Exponent-compare and alignment-control stage for half-precision (binary16) add/sub.
- Sits directly upstream of the 16-bit barrel shifter.
- Unpacks two operands, orders them by magnitude, and presents three results to the shifter:
  - the smaller operand's extended mantissa as shifter data;
  - a saturated 4-bit right-shift amount as shifter select;
  - the larger operand's fields, which pass to the adder.
- Two-stage elastic pipeline with valid/ready handshakes on both sides.

---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_align_ctrl_if.sv | 36 +++
 rtl/fp16_unpack.sv | 26 ++
 rtl/fp_align_ctrl.sv | 134 +++++++++++++
 tb/tb_fp_align_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the binary16 alignment-control slice: field widths,
// the unpacked operand record and the mantissa-extension helper.
package fp_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int SH_W   = 4;
    localparam int DATA_W = 2 ** SH_W;

    localparam logic [EXP_W-1:0] EXP_SPECIAL = 5'h1F;

    // One operand after unpacking; eff_exp is already corrected for subnormals.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  eff_exp;
        logic              hidden;
        logic [FRAC_W-1:0] frac;
    } fp16_unpacked_t;

    // Left-justify {hidden, frac} in the shifter data width so right shifts
    // keep guard bits below the fraction.
    function automatic logic [DATA_W-1:0] ext_mant(input fp16_unpacked_t u);
        return {u.hidden, u.frac, {(DATA_W-FRAC_W-1){1'b0}}};
    endfunction

endpackage

// File: rtl/fp_align_ctrl_if.sv
// Handshake and data bundle between the operand source, the alignment stage
// and the downstream shifter/adder.
interface fp_align_ctrl_if;
    import fp_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [15:0]       op_a;
    logic [15:0]       op_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] mant_big;
    logic [DATA_W-1:0] mant_small;
    logic [SH_W-1:0]   shamt;
    logic [EXP_W-1:0]  exp_big;
    logic              sign_big;
    logic              sign_small;
    logic              swap;
    logic              flush;
    logic              special;

    // Producer of operands and consumer of aligned results.
    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, mant_big, mant_small, shamt, exp_big,
               sign_big, sign_small, swap, flush, special
    );

    // The alignment stage itself.
    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, mant_big, mant_small, shamt, exp_big,
               sign_big, sign_small, swap, flush, special
    );

endinterface

// File: rtl/fp16_unpack.sv
// Combinational unpack of one binary16 operand into sign / effective exponent /
// hidden bit / fraction, plus its raw magnitude key for ordering.
module fp16_unpack
    import fp_pkg::*;
(
    input  logic [15:0]    i_op,
    output fp16_unpacked_t o_unp,
    output logic [14:0]    o_key
);

    logic [EXP_W-1:0] w_exp;

    assign w_exp = i_op[14:10];

    // Subnormals (exp==0) share the scale of exp==1 but have no hidden bit.
    always_comb begin
        o_unp.sign    = i_op[15];
        o_unp.hidden  = (w_exp != '0);
        o_unp.eff_exp = (w_exp == '0) ? EXP_W'(1) : w_exp;
        o_unp.frac    = i_op[FRAC_W-1:0];
    end

    // Raw {exp, frac} orders magnitudes correctly, subnormals included.
    assign o_key = i_op[14:0];

endmodule

// File: rtl/fp_align_ctrl.sv
// Exponent compare and alignment control ahead of the 16-bit barrel shifter.
// S1 captures both unpacked operands, the swap decision and the exponent
// difference; S2 orders the fields and saturates the shift amount.
module fp_align_ctrl
    import fp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    fp_align_ctrl_if.slave bus
);

    fp16_unpacked_t w_unp [2];
    logic [14:0]    w_key [2];
    logic [15:0]    w_op  [2];

    assign w_op[0] = bus.op_a;
    assign w_op[1] = bus.op_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            fp16_unpack u_unpack (
                .i_op  (w_op[gi]),
                .o_unp (w_unp[gi]),
                .o_key (w_key[gi])
            );
        end
    endgenerate

    // Ordering: B wins only on a strictly larger magnitude.
    logic             w_swap;
    logic [EXP_W-1:0] w_diff;

    assign w_swap = (w_key[1] > w_key[0]);
    assign w_diff = w_swap ? (w_unp[1].eff_exp - w_unp[0].eff_exp)
                           : (w_unp[0].eff_exp - w_unp[1].eff_exp);

    // Handshake: each stage moves when its downstream slot is free or draining.
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_adv;
    logic w_s1_adv;

    assign w_s2_adv     = !r_s2_valid || bus.out_ready;
    assign w_s1_adv     = !r_s1_valid || w_s2_adv;
    assign bus.in_ready = w_s1_adv;

    fp16_unpacked_t   r_s1_a;
    fp16_unpacked_t   r_s1_b;
    logic             r_s1_swap;
    logic [EXP_W-1:0] r_s1_diff;

    // Stage 1 register: raw unpacked operands, swap and exponent difference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_swap  <= 1'b0;
            r_s1_diff  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_a    <= w_unp[0];
                r_s1_b    <= w_unp[1];
                r_s1_swap <= w_swap;
                r_s1_diff <= w_diff;
            end
        end
    end

    // Stage 2 combinational ordering and saturation (diff[4] means >= 16).
    fp16_unpacked_t  w_big;
    fp16_unpacked_t  w_small;
    logic            w_flush;
    logic [SH_W-1:0] w_shamt;
    logic            w_special;

    assign w_big     = r_s1_swap ? r_s1_b : r_s1_a;
    assign w_small   = r_s1_swap ? r_s1_a : r_s1_b;
    assign w_flush   = r_s1_diff[EXP_W-1];
    assign w_shamt   = w_flush ? {SH_W{1'b1}} : r_s1_diff[SH_W-1:0];
    assign w_special = (r_s1_a.eff_exp == EXP_SPECIAL) || (r_s1_b.eff_exp == EXP_SPECIAL);

    logic [DATA_W-1:0] r_mant_big;
    logic [DATA_W-1:0] r_mant_small;
    logic [SH_W-1:0]   r_shamt;
    logic [EXP_W-1:0]  r_exp_big;
    logic              r_sign_big;
    logic              r_sign_small;
    logic              r_swap;
    logic              r_flush;
    logic              r_special;

    // Stage 2 register: holds the result steady while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_mant_big   <= '0;
            r_mant_small <= '0;
            r_shamt      <= '0;
            r_exp_big    <= '0;
            r_sign_big   <= 1'b0;
            r_sign_small <= 1'b0;
            r_swap       <= 1'b0;
            r_flush      <= 1'b0;
            r_special    <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_mant_big   <= ext_mant(w_big);
                r_mant_small <= w_flush ? '0 : ext_mant(w_small);
                r_shamt      <= w_shamt;
                r_exp_big    <= w_big.eff_exp;
                r_sign_big   <= w_big.sign;
                r_sign_small <= w_small.sign;
                r_swap       <= r_s1_swap;
                r_flush      <= w_flush;
                r_special    <= w_special;
            end
        end
    end

    assign bus.out_valid  = r_s2_valid;
    assign bus.mant_big   = r_mant_big;
    assign bus.mant_small = r_mant_small;
    assign bus.shamt      = r_shamt;
    assign bus.exp_big    = r_exp_big;
    assign bus.sign_big   = r_sign_big;
    assign bus.sign_small = r_sign_small;
    assign bus.swap       = r_swap;
    assign bus.flush      = r_flush;
    assign bus.special    = r_special;

endmodule

// File: tb/tb_fp_align_ctrl.sv
// Bench for fp_align_ctrl: directed cases plus random traffic with random
// backpressure, checked against a transaction-level reference model.
module tb_fp_align_ctrl;

    typedef struct packed {
        logic [15:0] mb;
        logic [15:0] ms;
        logic [3:0]  sh;
        logic [4:0]  eb;
        logic        sb;
        logic        ss;
        logic        sw;
        logic        fl;
        logic        sp;
    } res_t;

    typedef struct {
        res_t r;
        int   stamp;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fp_align_ctrl_if bus ();

    fp_align_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    int    pops  = 0;
    res_t  last_res;
    bit    last_acc_in;
    item_t q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_exp(input logic [15:0] x);
        return (x[14:10] == 5'd0) ? 1 : int'(x[14:10]);
    endfunction

    function automatic int mant_of(input logic [15:0] x);
        return ((x[14:10] != 5'd0) ? 32768 : 0) + int'(x[9:0]) * 32;
    endfunction

    // Reference: order by magnitude, take the exponent gap, saturate.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
        res_t        r;
        logic [15:0] big;
        logic [15:0] sml;
        int          d;
        r.sw = (int'(b[14:0]) > int'(a[14:0]));
        big  = r.sw ? b : a;
        sml  = r.sw ? a : b;
        d    = eff_exp(big) - eff_exp(sml);
        r.sh = (d > 15) ? 4'd15 : 4'(d);
        r.fl = (d >= 16);
        r.mb = 16'(mant_of(big));
        r.ms = r.fl ? 16'd0 : 16'(mant_of(sml));
        r.eb = 5'(eff_exp(big));
        r.sb = big[15];
        r.ss = sml[15];
        r.sp = (a[14:10] == 5'd31) || (b[14:10] == 5'd31);
        return r;
    endfunction

    function automatic res_t observed();
        return {bus.mant_big, bus.mant_small, bus.shamt, bus.exp_big, bus.sign_big,
                bus.sign_small, bus.swap, bus.flush, bus.special};
    endfunction

    // One clock: drive at negedge, check handshake and head-of-queue result,
    // update the model with whatever transfers on the coming edge.
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b, input logic ordy);
        bit   exp_ov;
        res_t o;
        @(negedge clk);
        bus.in_valid  = v;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.out_ready = ordy;
        #1;
        exp_ov = (q.size() > 0) && (cyc - q[0].stamp >= 2);
        chk("in_ready", 64'(bus.in_ready), 64'(!(q.size() == 2 && !ordy)));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
        if (exp_ov && bus.out_valid) begin
            o = observed();
            chk("result", 64'(o), 64'(q[0].r));
            if (ordy) begin
                last_res = o;
                pops++;
                $display("[TB] out #%0d mb=%h ms=%h sh=%0d eb=%0d sw=%0d fl=%0d sp=%0d",
                         pops, o.mb, o.ms, o.sh, o.eb, o.sw, o.fl, o.sp);
                void'(q.pop_front());
            end
        end
        last_acc_in = v && bus.in_ready;
        if (last_acc_in) q.push_back('{r: model(a, b), stamp: cyc});
        @(posedge clk);
        cyc++;
    endtask

    task automatic directed(input logic [15:0] a, input logic [15:0] b);
        int p0;
        p0 = pops;
        cycle(1'b1, a, b, 1'b1);
        repeat (3) cycle(1'b0, 16'h0, 16'h0, 1'b1);
        chk("directed_emerged", 64'(pops - p0), 64'd1);
    endtask

    function automatic logic [15:0] rand_op();
        logic [4:0] e;
        case ($urandom_range(0, 5))
            0: e = 5'd0;
            1: e = 5'd1;
            2: e = 5'd31;
            3: e = 5'd30;
            default: e = 5'($urandom_range(0, 31));
        endcase
        return {1'($urandom), e, 10'($urandom)};
    endfunction

    initial begin
        int          sent;
        int          p0;
        logic [15:0] ra;
        logic [15:0] rb;

        bus.in_valid  = 1'b0;
        bus.op_a      = 16'h0;
        bus.op_b      = 16'h0;
        bus.out_ready = 1'b0;
        #1;
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_mant_big", 64'(bus.mant_big), 64'd0);
        chk("reset_shamt", 64'(bus.shamt), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        directed(16'h3C00, 16'h3800);
        chk("basic_mb", 64'(last_res.mb), 64'h8000);
        chk("basic_ms", 64'(last_res.ms), 64'h8000);
        chk("basic_sh", 64'(last_res.sh), 64'd1);
        chk("basic_eb", 64'(last_res.eb), 64'd15);
        chk("basic_sw_fl", 64'({last_res.sw, last_res.fl}), 64'd0);

        directed(16'h3800, 16'h3C00);
        chk("swap_sw_sh_eb", 64'({last_res.sw, last_res.sh, last_res.eb}), 64'({1'b1, 4'd1, 5'd15}));
        directed(16'h4200, 16'h4200);
        chk("equal_sw_sh", 64'({last_res.sw, last_res.sh}), 64'd0);

        directed(16'h7800, 16'h3C00);
        chk("sat15_sh_fl", 64'({last_res.sh, last_res.fl}), 64'({4'd15, 1'b0}));
        directed(16'h7800, 16'h3800);
        chk("flush_sh_fl_ms", 64'({last_res.sh, last_res.fl, last_res.ms}), 64'({4'd15, 1'b1, 16'h0}));

        directed(16'h0400, 16'h0001);
        chk("subn_eb_sh", 64'({last_res.eb, last_res.sh}), 64'({5'd1, 4'd0}));
        chk("subn_ms_mb", 64'({last_res.ms, last_res.mb}), 64'({16'h0020, 16'h8000}));
        directed(16'h7C00, 16'h3C00);
        chk("special", 64'(last_res.sp), 64'd1);

        // Back-to-back stream with downstream stalled for four cycles.
        sent = 0;
        p0   = pops;
        for (int i = 0; i < 14; i++) begin
            cycle(sent < 4, 16'h3C00 + 16'(sent * 16'h0400), 16'h3800 - 16'(sent), !(i >= 1 && i <= 4));
            if (last_acc_in) sent++;
        end
        chk("bp_all_sent", 64'(sent), 64'd4);
        chk("bp_all_out", 64'(pops - p0), 64'd4);

        // Reset asserted between edges with two items in flight.
        cycle(1'b1, 16'h3C00, 16'h0001, 1'b1);
        cycle(1'b1, 16'h5000, 16'h4000, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        p0 = pops;
        repeat (4) cycle(1'b0, 16'h0, 16'h0, 1'b1);
        chk("midrst_no_stale", 64'(pops - p0), 64'd0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            ra = rand_op();
            rb = ($urandom_range(0, 7) == 0) ? ra : rand_op();
            cycle(1'($urandom), ra, rb, ($urandom_range(0, 3) != 0));
        end
        repeat (6) cycle(1'b0, 16'h0, 16'h0, 1'b1);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
